// File: rtl/onehot_encoder_4to2_seq.sv
// Streaming 4-to-2 encoder: accepts a request vector and emits the index of every
// set bit, lowest first, one per output handshake; a zero vector gives one flagged beat.
module onehot_encoder_4to2_seq #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic             dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and in_ready is decoded from state alone.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_pending;
    logic [N-1:0]       w_pending_nxt;
    logic [IDX_W-1:0]   r_out_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_out_last;
    logic               w_last_nxt;
    logic               r_out_zero;
    logic               w_zero_nxt;
    logic [N-1:0]       w_clear_mask;
    logic [N-1:0]       w_remaining;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    always_comb begin
        w_clear_mask            = '0;
        w_clear_mask[r_out_idx] = 1'b1;
    end

    assign w_remaining = r_pending & ~w_clear_mask;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_idx_nxt     = r_out_idx;
        w_last_nxt    = r_out_last;
        w_zero_nxt    = r_out_zero;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt   = S_EMIT;
                    w_pending_nxt = in_vec;
                    w_idx_nxt     = lowest_idx(in_vec);
                    w_last_nxt    = (in_vec == '0) || single_bit(in_vec);
                    w_zero_nxt    = (in_vec == '0);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = w_remaining;
                    if (r_out_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt  = lowest_idx(w_remaining);
                        w_last_nxt = single_bit(w_remaining);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
            r_out_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_out_idx  <= w_idx_nxt;
            r_out_last <= w_last_nxt;
            r_out_zero <= w_zero_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_EMIT);
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_zero  = r_out_zero;
    assign dbg_state = r_state;

endmodule

// File: doc/onehot_encoder_4to2_seq.md
Name: onehot_encoder_4to2_seq

Overview:
- Streaming 4-to-2 encoder; inverse of the team's 2-to-4 one-hot decoder.
- Accepts a 4-bit request vector over a valid/ready handshake.
- Emits the index of every set bit as a serial stream, lowest index first, one index per output handshake.
- A zero vector produces a single flagged beat.
- Used to turn decoded one-hot or multi-hot select lines back into binary indices for downstream logging and muxing.

Parameters:
- N, 4, input vector width; fixed at 4 in this revision.
- IDX_W, 2, output index width (= log2 N); fixed at 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_vec is valid this cycle.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  4  request vector, any bit pattern.
- out_valid  output  1  out_idx, out_last and out_zero are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  2  binary index of the current set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_zero  output  1  accepted vector was all zeros; out_idx = 0 on that beat.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. All flops clear immediately when rst_n falls. Inputs are ignored while rst_n = 0.
- Reset values:
  - state = IDLE, pending = 4'b0000.
  - out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0.
  - in_ready = 1, because it is decoded from IDLE.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - EMIT: in_ready = 0, out_valid = 1.
- in_ready is combinational from state only; there is no combinational path from out_ready to in_ready.
- Accept (IDLE, in_valid = 1):
  - pending <= in_vec, next state EMIT.
  - First beat is registered: out_valid = 1 the cycle after accept, so latency is 1 cycle.
- First beat values:
  - in_vec != 0: out_idx = lowest set bit, out_last = (exactly one bit set), out_zero = 0.
  - in_vec == 0: out_idx = 0, out_last = 1, out_zero = 1.
- Beat handshake (EMIT, out_ready = 1):
  - Clear the emitted bit from pending.
  - If out_last = 1: go to IDLE and drop out_valid next cycle.
  - Otherwise load the next lowest set bit of the remaining pending into out_idx. out_last = 1 iff exactly one bit remains after clearing.
- Backpressure (EMIT, out_ready = 0): out_idx, out_last, out_zero and pending hold stable; out_valid stays 1.
- No overlap: a new vector is accepted only in IDLE. After the last beat's handshake there is exactly one IDLE cycle before the next accept can occur. Sustained throughput is popcount(vec) + 1 cycles per vector (2 for a zero vector).
- in_valid while in EMIT has no effect; the upstream must hold its data.
- Beats per vector: popcount(in_vec) beats (1 to 4), or 1 beat for a zero vector.
- Ordering: strictly ascending index. Example: 4'b1111 produces 0, 1, 2, 3, with out_last only on 3.
- Reset mid-EMIT: the stream aborts immediately and the remaining beats are discarded. The block returns to IDLE with in_ready = 1 after rst_n rises.
- out_* values while out_valid = 0 are don't-care for the consumer. The RTL holds them at their last value, or at 0 after reset.

Test Plan:
1. Reset → out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0, in_ready = 1; rst_n asserted asynchronously mid-cycle clears outputs without a clock edge.
2. One-hot sweep: send 4'b0001, 0010, 0100, 1000 with out_ready = 1 → one beat each, out_idx = 0, 1, 2, 3, out_last = 1, out_valid rising 1 cycle after accept. Also run a round-trip with the 2-to-4 decoder output feeding in_vec: out_idx equals the decoder's input.
3. Multi-hot 4'b1011, out_ready = 1 → three consecutive beats with out_idx 0, 1, 3 and out_last = 0, 0, 1; in_ready low for the whole burst.
4. Zero vector 4'b0000 → single beat: out_zero = 1, out_idx = 0, out_last = 1; no second beat.
5. Backpressure on 4'b0110: hold out_ready = 0 for 3 cycles on the first beat → out_idx = 1 held stable with out_valid = 1; then release → idx 2 with out_last = 1; in_valid pulses during EMIT are ignored.
6. Reset during EMIT of 4'b1111 after the second beat → outputs clear, no further beats. The next vector 4'b1000 after reset yields idx 3, last 1.
